// File: rtl/pc_issue_if.sv
// Handshake and control bundle between pc_issue_stage and the fetch register.
// The trap/trap_addr members exist only when PC_MISALIGN_TRAP_EN is defined.
interface pc_issue_if;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic [31:0] issue_count;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
  logic [31:0] trap_addr;

  modport master (
    input  ready_in, redirect_valid, redirect_target, halt_req,
    output valid_out, data_out, halted, issue_count, trap, trap_addr
  );
  modport slave (
    output ready_in, redirect_valid, redirect_target, halt_req,
    input  valid_out, data_out, halted, issue_count, trap, trap_addr
  );
`else
  modport master (
    input  ready_in, redirect_valid, redirect_target, halt_req,
    output valid_out, data_out, halted, issue_count
  );
  modport slave (
    output ready_in, redirect_valid, redirect_target, halt_req,
    input  valid_out, data_out, halted, issue_count
  );
`endif
endinterface

// File: rtl/pc_issue_stage.sv
// Sequential PC issue stage: valid/ready transmitter with redirect, halt and drain.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_issue_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic         CLK,
  input logic         RST,
  input logic         CE,
  pc_issue_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid;
  logic        xfer;
  logic        redir_ok;
  logic        redir_bad;
  logic        trap_hold;

  assign valid    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign xfer     = valid && bus.ready_in;
  assign redir_ok = bus.redirect_valid && !redir_bad;

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;

  assign redir_bad     = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
  assign trap_hold     = trap_q;
  assign bus.trap      = trap_q;
  assign bus.trap_addr = trap_addr_q;

  always_comb begin
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    if (redir_bad && (state_q != S_IDLE)) begin
      trap_d      = 1'b1;
      trap_addr_d = bus.redirect_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else if (CE) begin
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end
`else
  assign redir_bad = 1'b0;
  assign trap_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    // Transfer bookkeeping first; a valid redirect then overrides the address
    // while the transfer is still counted.
    if (xfer) begin
      cnt_d = cnt_q + 32'd1;
      pc_d  = pc_q + PC_STEP;
    end
    if (redir_ok) pc_d = bus.redirect_target & ~32'd3;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
        pc_d    = pc_q;
      end
      S_RUN: begin
        if (redir_bad)
          state_d = S_HALT;
        else if (bus.halt_req)
          state_d = (xfer || redir_ok) ? S_HALT : S_DRAIN;
      end
      S_DRAIN: begin
        if (redir_bad || redir_ok || (xfer && bus.halt_req))
          state_d = S_HALT;
        else if (!bus.halt_req)
          state_d = S_RUN;
      end
      S_HALT: begin
        if (!bus.halt_req && !trap_hold && !redir_bad)
          state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else if (CE) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_out   = valid;
  assign bus.data_out    = pc_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_pc_issue_stage.sv
// Randomized bench for pc_issue_stage against a flag-level reference model,
// plus a second instance with RESET_PC near the top of the address space.
module tb_pc_issue_stage;

  logic        CLK = 1'b0;
  logic        rst, ce, ready, redir, halt;
  logic [31:0] tgt;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  pc_issue_if bus0 ();
  pc_issue_if bus1 ();

  assign bus0.ready_in        = ready;
  assign bus0.redirect_valid  = redir;
  assign bus0.redirect_target = tgt;
  assign bus0.halt_req        = halt;
  assign bus1.ready_in        = ready;
  assign bus1.redirect_valid  = redir;
  assign bus1.redirect_target = tgt;
  assign bus1.halt_req        = halt;

  pc_issue_stage dut0 (.CLK(CLK), .RST(rst), .CE(ce), .bus(bus0));
  pc_issue_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4))
    dut1 (.CLK(CLK), .RST(rst), .CE(ce), .bus(bus1));

  always #5 CLK = ~CLK;

  // Reference model: started / issuing / draining / stopped flags, PC, count
  logic        m_start, m_valid, m_drain, m_halt, m_trap;
  logic [31:0] m_pc, m_cnt, m_taddr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    logic xfer, bad, stopping, draining;
    logic [31:0] npc;
    if (rst) begin
      m_start = 0; m_valid = 0; m_drain = 0; m_halt = 0; m_trap = 0;
      m_pc = 32'h0; m_cnt = 0; m_taddr = 0;
    end else if (ce) begin
      xfer = m_valid && ready;
      npc  = xfer ? m_pc + 32'd4 : m_pc;
      if (xfer) m_cnt = m_cnt + 1;
`ifdef PC_MISALIGN_TRAP_EN
      bad = redir && (tgt % 4 != 0);
`else
      bad = 1'b0;
`endif
      if (!m_start) begin
        m_start = 1; m_valid = 1;
      end else if (bad) begin
        m_trap = 1; m_taddr = tgt; m_pc = npc;
        m_valid = 0; m_halt = 1; m_drain = 0;
      end else begin
        m_pc = redir ? (tgt / 4) * 4 : npc;
        if (m_halt)       stopping = halt || m_trap;
        else if (m_drain) stopping = redir || (xfer && halt);
        else              stopping = halt && (xfer || redir);
        draining = !m_halt && m_valid && halt && !xfer && !redir;
        m_halt = stopping; m_valid = !stopping; m_drain = draining;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    check_eq("valid_out",   {31'b0, bus0.valid_out}, {31'b0, m_valid});
    check_eq("halted",      {31'b0, bus0.halted},    {31'b0, m_halt});
    check_eq("data_out",    bus0.data_out,           m_pc);
    check_eq("issue_count", bus0.issue_count,        m_cnt);
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("trap",        {31'b0, bus0.trap},      {31'b0, m_trap});
    check_eq("trap_addr",   bus0.trap_addr,          m_taddr);
`endif
  endtask

  initial begin
    rst = 1; ce = 1; ready = 1; redir = 0; halt = 0; tgt = '0;
    step(); step();
    check_eq("rst_valid", {31'b0, bus0.valid_out}, 32'd0);
    check_eq("rst_pc1",   bus1.data_out, 32'hFFFF_FFF8);
    rst = 0;
    step(); check_eq("wrap0", bus1.data_out, 32'hFFFF_FFF8);
    check_eq("first_valid", {31'b0, bus0.valid_out}, 32'd1);
    step(); check_eq("wrap1", bus1.data_out, 32'hFFFF_FFFC);
    step(); check_eq("wrap2", bus1.data_out, 32'h0000_0000);
    check_eq("pc_seq", bus0.data_out, 32'd8);
    ce = 0;
    repeat (3) begin
      step();
      check_eq("ce_freeze_pc",  bus1.data_out,    32'h0);
      check_eq("ce_freeze_cnt", bus1.issue_count, 32'd2);
    end
    ce = 1; ready = 0;
    repeat (5) step();
    check_eq("stall_pc", bus0.data_out, 32'd8);
    ready = 1; step(); step();
    check_eq("after_stall_cnt", bus0.issue_count, 32'd4);
    ready = 0; redir = 1; tgt = 32'h0000_2003;
    step();
    redir = 0;
    check_eq("redir_addr", bus0.data_out, 32'h0000_2000);
    check_eq("redir_cnt",  bus0.issue_count, 32'd4);
    halt = 1; step();
    check_eq("drain_valid", {31'b0, bus0.valid_out}, 32'd1);
    ready = 1; step();
    check_eq("halt_pc", bus0.data_out, 32'h0000_2004);
    check_eq("halted",  {31'b0, bus0.halted}, 32'd1);
    ready = 0; halt = 0; step();
    check_eq("resume_valid", {31'b0, bus0.valid_out}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 300) == 0;
      ce    = ($urandom % 8) != 0;
      ready = ($urandom % 3) != 0;
      redir = ($urandom % 12) == 0;
      tgt   = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
      if (($urandom % 8) != 0) tgt[1:0] = 2'b00;
`endif
      if (($urandom % 10) == 0) halt = ~halt;
      step();
    end

`ifdef PC_MISALIGN_TRAP_EN
    rst = 1; ce = 1; ready = 1; redir = 0; halt = 0;
    step(); rst = 0; step(); step();
    redir = 1; tgt = 32'h0000_1002; step(); redir = 0;
    check_eq("trap_set",  {31'b0, bus0.trap}, 32'd1);
    check_eq("trap_addr_val", bus0.trap_addr, 32'h0000_1002);
    repeat (3) step();
    check_eq("trap_no_resume", {31'b0, bus0.valid_out}, 32'd0);
    rst = 1; step(); rst = 0;
    check_eq("trap_clear", {31'b0, bus0.trap}, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
